// File: rtl/io_bus_fabric.sv
// IO bus fabric: registered address decode, req/ack handshake to N slave lanes and a shared device tick.
// Optional WAIT-state timeout is compiled in with `define IO_BUS_TIMEOUT_EN.
module io_bus_fabric #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 4,
  parameter int N_SLOT      = 3,
  parameter int DEV_LSB     = 4,
  parameter int DEV_W       = 4,
  parameter logic [(N_SLOT-1)*DEV_W-1:0] SLOT_CODES = {4'h6, 4'h0},
  parameter int IO_PREFIX_W = 20,
  parameter int DEV_DIV     = 50000,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_req,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [CTRL_W-1:0]        m_ctrl,
  input  logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_ack,
  output logic                     m_err,
  output logic [N_SLOT-1:0]        s_sel,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [CTRL_W-1:0]        s_ctrl,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic [N_SLOT*DATA_W-1:0] s_rdata,
  input  logic [N_SLOT-1:0]        s_ack,
  output logic                     dev_tick
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int TICK_W = (DEV_DIV > 2) ? $clog2(DEV_DIV) : 1;

  logic [1:0]        state_q, state_d;
  logic              err_q;
  logic [N_SLOT-1:0] sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick_q;

  logic [N_SLOT-1:0] hit;
  logic              mapped;
  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;
  logic              timeout;

  // Decode: outside the IO window is RAM; inside, code bit 0 is a don't-care and the lowest slot wins.
  always_comb begin
    hit = '0;
    if (!(&m_addr[ADDR_W-1 -: IO_PREFIX_W])) begin
      hit[0] = 1'b1;
    end else begin
      for (int k = N_SLOT - 1; k >= 1; k--) begin
        if (m_addr[DEV_LSB+DEV_W-1:DEV_LSB+1] == SLOT_CODES[(k-1)*DEV_W+1 +: DEV_W-1]) begin
          hit    = '0;
          hit[k] = 1'b1;
        end
      end
    end
  end

  assign mapped  = |hit;
  assign ack_sel = |(s_ack & sel_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | s_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_WAIT || ack_sel) begin
      to_cnt_q <= '0;
    end else if (!timeout) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (m_req) state_d = mapped ? ST_WAIT : ST_RESP;
      ST_WAIT: if (ack_sel || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (m_req && mapped) begin
            sel_q   <= hit;
            addr_q  <= m_addr;
            ctrl_q  <= m_ctrl;
            wdata_q <= m_wdata;
            err_q   <= 1'b0;
          end else if (m_req) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        ST_WAIT: begin
          // A same-cycle ack takes priority over timeout expiry.
          if (ack_sel) begin
            rdata_q <= rdata_sel;
            sel_q   <= '0;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            sel_q   <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running divider; the pulse is registered so the first one lands DEV_DIV cycles after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q     <= (tick_cnt_q == TICK_W'(DEV_DIV - 1));
      tick_cnt_q <= (tick_cnt_q == TICK_W'(DEV_DIV - 1)) ? '0 : tick_cnt_q + 1'b1;
    end
  end

  assign m_ack    = (state_q == ST_RESP) && !err_q;
  assign m_err    = (state_q == ST_RESP) &&  err_q;
  assign m_rdata  = rdata_q;
  assign s_sel    = sel_q;
  assign s_addr   = addr_q;
  assign s_ctrl   = ctrl_q;
  assign s_wdata  = wdata_q;
  assign dev_tick = tick_q;

endmodule
